// File: rtl/fb_frame_reader.sv
// Read-DMA controller: streams one frame from SDRAM via Avalon-MM burst reads
// into a pixel FIFO write slave through a credit-managed skid buffer.
module fb_frame_reader #(
  parameter int FRAME_WORDS = 307200,
  parameter int BURST_LEN   = 8,
  parameter int SKID_DEPTH  = 16,
  parameter int BC_W        = 7
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [31:0]     frame_base,
  output logic            busy,
  output logic            done,
  output logic            overflow,
  output logic [31:0]     m_address,
  output logic            m_read,
  output logic [BC_W-1:0] m_burstcount,
  input  logic            m_waitrequest,
  input  logic [31:0]     m_readdata,
  input  logic            m_readdatavalid,
  output logic            f_address,
  output logic            f_write,
  output logic [31:0]     f_writedata,
  input  logic            f_waitrequest
);

  localparam int PTR_W = (SKID_DEPTH > 1) ? $clog2(SKID_DEPTH) : 1;
  localparam int CNT_W = $clog2(SKID_DEPTH + 1);

  localparam logic [1:0] IDLE       = 2'd0;
  localparam logic [1:0] REQ        = 2'd1;
  localparam logic [1:0] WAITCREDIT = 2'd2;
  localparam logic [1:0] FLUSH      = 2'd3;

  logic [1:0]       state;
  logic [31:0]      remaining;
  logic [CNT_W-1:0] pending;
  logic [CNT_W-1:0] occupancy;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [31:0]      skid_mem [SKID_DEPTH];

  logic        accept;
  logic        rdv_live;
  logic        pop;
  logic        full;
  logic        do_push;
  logic        pend_dec;
  logic [31:0] bc_w;
  logic [31:0] occ_next;
  logic [31:0] pend_next;
  logic [31:0] rem_next;
  logic [31:0] next_bc;
  logic [31:0] first_bc;
  logic        credit_next;
  logic        credit_first;
  logic        credit_hold;

  function automatic logic [31:0] clip_burst(input logic [31:0] words);
    return (words < 32'(BURST_LEN)) ? words : 32'(BURST_LEN);
  endfunction

  function automatic logic credit_ok(input logic [31:0] occ,
                                     input logic [31:0] pend,
                                     input logic [31:0] bc);
    return (occ + pend + bc) <= 32'(SKID_DEPTH);
  endfunction

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(SKID_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign f_address   = 1'b0;
  assign f_write     = (occupancy != '0);
  assign f_writedata = skid_mem[rd_ptr];

  // Credit decisions use next-cycle occupancy/pending so a newly raised m_read
  // is already covered by space that cannot be consumed before its data lands.
  always_comb begin
    accept       = m_read & ~m_waitrequest;
    rdv_live     = m_readdatavalid & (state != IDLE);
    pop          = f_write & ~f_waitrequest;
    full         = (occupancy == CNT_W'(SKID_DEPTH));
    do_push      = rdv_live & (~full | pop);
    pend_dec     = rdv_live & (pending != '0);
    bc_w         = 32'(m_burstcount);
    occ_next     = 32'(occupancy) + 32'(do_push) - 32'(pop);
    pend_next    = 32'(pending) + (accept ? bc_w : 32'd0) - 32'(pend_dec);
    rem_next     = remaining - (accept ? bc_w : 32'd0);
    next_bc      = clip_burst(rem_next);
    first_bc     = clip_burst(32'(FRAME_WORDS));
    credit_next  = credit_ok(occ_next, pend_next, next_bc);
    credit_first = credit_ok(occ_next, pend_next, first_bc);
    credit_hold  = credit_ok(occ_next, pend_next, bc_w);
  end

  // With the buffer full, a simultaneous pop frees the head slot, which is
  // exactly the slot wr_ptr points at, so the push may reuse it.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occupancy <= '0;
      overflow  <= 1'b0;
      for (int i = 0; i < SKID_DEPTH; i++) skid_mem[i] <= '0;
    end else begin
      if (do_push) begin
        skid_mem[wr_ptr] <= m_readdata;
        wr_ptr           <= ptr_inc(wr_ptr);
      end
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
      occupancy <= CNT_W'(occ_next);
      if (rdv_live & full & ~pop) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      busy         <= 1'b0;
      done         <= 1'b0;
      m_read       <= 1'b0;
      m_address    <= '0;
      m_burstcount <= '0;
      remaining    <= '0;
      pending      <= '0;
    end else begin
      done    <= 1'b0;
      pending <= CNT_W'(pend_next);
      case (state)
        IDLE: begin
          if (start) begin
            m_address    <= frame_base;
            remaining    <= 32'(FRAME_WORDS);
            m_burstcount <= BC_W'(first_bc);
            busy         <= 1'b1;
            if (credit_first) begin
              state  <= REQ;
              m_read <= 1'b1;
            end else begin
              state <= WAITCREDIT;
            end
          end
        end
        REQ: begin
          if (accept) begin
            m_address    <= m_address + (bc_w << 2);
            remaining    <= rem_next;
            m_burstcount <= BC_W'(next_bc);
            if (rem_next == 32'd0) begin
              state  <= FLUSH;
              m_read <= 1'b0;
            end else if (credit_next) begin
              m_read <= 1'b1;
            end else begin
              state  <= WAITCREDIT;
              m_read <= 1'b0;
            end
          end
        end
        WAITCREDIT: begin
          if (credit_hold) begin
            state  <= REQ;
            m_read <= 1'b1;
          end
        end
        FLUSH: begin
          if (pend_next == 32'd0 && occ_next == 32'd0) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fb_frame_reader.sv
// Self-checking bench for fb_frame_reader: an SDRAM slave model returns
// address-derived words and a scoreboard checks FIFO writes in frame order.
module tb_fb_frame_reader;

  localparam int FRAME_WORDS = 20;
  localparam int BURST_LEN   = 8;
  localparam int SKID_DEPTH  = 16;
  localparam int BC_W        = 7;

  logic            clk;
  logic            reset;
  logic            start;
  logic [31:0]     frame_base;
  logic            busy;
  logic            done;
  logic            overflow;
  logic [31:0]     m_address;
  logic            m_read;
  logic [BC_W-1:0] m_burstcount;
  logic            m_waitrequest;
  logic [31:0]     m_readdata;
  logic            m_readdatavalid;
  logic            f_address;
  logic            f_write;
  logic [31:0]     f_writedata;
  logic            f_waitrequest;

  int checks = 0;
  int passes = 0;

  logic [31:0] exp_q [$];
  logic [31:0] ret_q [$];
  logic [31:0] burst_addr_q [$];
  int          burst_len_q [$];

  int words_acc   = 0;
  int words_ret   = 0;
  int writes      = 0;
  int bursts_seen = 0;
  int done_cnt    = 0;
  int extra_words = 0;
  int stall_burst = -1;
  int stall_left  = 0;
  bit fifo_full   = 1'b0;

  bit              hold_valid = 1'b0;
  logic [31:0]     hold_addr;
  logic [BC_W-1:0] hold_bc;
  logic [31:0]     exp_w;
  logic [31:0]     ret_a;

  fb_frame_reader #(
    .FRAME_WORDS(FRAME_WORDS),
    .BURST_LEN  (BURST_LEN),
    .SKID_DEPTH (SKID_DEPTH),
    .BC_W       (BC_W)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .frame_base     (frame_base),
    .busy           (busy),
    .done           (done),
    .overflow       (overflow),
    .m_address      (m_address),
    .m_read         (m_read),
    .m_burstcount   (m_burstcount),
    .m_waitrequest  (m_waitrequest),
    .m_readdata     (m_readdata),
    .m_readdatavalid(m_readdatavalid),
    .f_address      (f_address),
    .f_write        (f_write),
    .f_writedata    (f_writedata),
    .f_waitrequest  (f_waitrequest)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: time limit reached, required test completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0F0F_1234;
  endfunction

  // Bus models run at posedge+1; tasks act at posedge+2 so they never race.
  initial begin
    m_waitrequest   = 1'b0;
    m_readdatavalid = 1'b0;
    m_readdata      = '0;
    f_waitrequest   = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (done === 1'b1) done_cnt++;
      f_waitrequest = fifo_full;
      if (f_write === 1'b1 && !fifo_full) begin
        writes++;
        checks++;
        if (exp_q.size() == 0) begin
          $display("[TB] FAIL fifo_write: got unexpected write data %h, required no write", f_writedata);
        end else begin
          exp_w = exp_q.pop_front();
          if (f_writedata !== exp_w)
            $display("[TB] FAIL fifo_data: got %h, required %h", f_writedata, exp_w);
          else
            passes++;
        end
      end
      if (ret_q.size() > 0) begin
        ret_a           = ret_q.pop_front();
        m_readdatavalid = 1'b1;
        m_readdata      = word_of(ret_a);
        words_ret++;
      end else if (extra_words > 0) begin
        extra_words--;
        m_readdatavalid = 1'b1;
        m_readdata      = 32'hDEAD_BEEF;
      end else begin
        m_readdatavalid = 1'b0;
        m_readdata      = '0;
      end
      m_waitrequest = 1'b0;
      if (m_read === 1'b1) begin
        if (hold_valid) begin
          checks++;
          if (m_address !== hold_addr || m_burstcount !== hold_bc)
            $display("[TB] FAIL burst_hold: got addr %h bc %0d, required addr %h bc %0d",
                     m_address, m_burstcount, hold_addr, hold_bc);
          else
            passes++;
        end
        if (bursts_seen == stall_burst && stall_left > 0) begin
          m_waitrequest = 1'b1;
          stall_left--;
          if (!hold_valid) begin
            hold_valid = 1'b1;
            hold_addr  = m_address;
            hold_bc    = m_burstcount;
          end
        end else begin
          hold_valid = 1'b0;
          burst_addr_q.push_back(m_address);
          burst_len_q.push_back(int'(m_burstcount));
          for (int k = 0; k < int'(m_burstcount); k++)
            ret_q.push_back(m_address + 32'(4 * k));
          words_acc += int'(m_burstcount);
          bursts_seen++;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic start_frame(input logic [31:0] base);
    frame_base = base;
    start      = 1'b1;
    for (int i = 0; i < FRAME_WORDS; i++) exp_q.push_back(word_of(base + 32'(4 * i)));
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset      = 1'b1;
    start      = 1'b0;
    frame_base = '0;
    repeat (3) tick();
    checks++;
    if ({busy, done, overflow, m_read, f_write, f_address} !== 6'b0)
      $display("[TB] FAIL reset_ctrl: got %b, required 000000",
               {busy, done, overflow, m_read, f_write, f_address});
    else passes++;
    checks++;
    if (m_address !== 32'd0 || m_burstcount !== '0)
      $display("[TB] FAIL reset_addr: got addr %h bc %0d, required 0 and 0", m_address, m_burstcount);
    else passes++;
    checks++;
    if (f_writedata !== 32'd0)
      $display("[TB] FAIL reset_wdata: got %h, required 0", f_writedata);
    else passes++;
    reset = 1'b0;
    tick();
  endtask

  task automatic test_basic_frame();
    logic [31:0] exp_addr [3];
    int          exp_len  [3];
    int          n;
    exp_addr = '{32'h1000, 32'h1020, 32'h1040};
    exp_len  = '{8, 8, 4};
    burst_addr_q.delete();
    burst_len_q.delete();
    writes   = 0;
    done_cnt = 0;
    start_frame(32'h1000);
    checks++;
    if (m_read !== 1'b1 || busy !== 1'b1)
      $display("[TB] FAIL first_read: got m_read %b busy %b, required 1 1", m_read, busy);
    else passes++;
    n = 0;
    while (done !== 1'b1 && n < 300) begin tick(); n++; end
    checks++;
    if (done !== 1'b1) $display("[TB] FAIL basic_done: got no done in 300 cycles, required done");
    else passes++;
    checks++;
    if (busy !== 1'b0) $display("[TB] FAIL basic_busy_fall: got busy %b in done cycle, required 0", busy);
    else passes++;
    repeat (5) tick();
    checks++;
    if (done_cnt != 1 || writes != FRAME_WORDS || exp_q.size() != 0)
      $display("[TB] FAIL basic_counts: got done %0d writes %0d left %0d, required 1 %0d 0",
               done_cnt, writes, exp_q.size(), FRAME_WORDS);
    else passes++;
    checks++;
    if (burst_addr_q.size() != 3)
      $display("[TB] FAIL burst_count: got %0d bursts, required 3", burst_addr_q.size());
    else passes++;
    for (int i = 0; i < 3 && i < burst_addr_q.size(); i++) begin
      checks++;
      if (burst_addr_q[i] !== exp_addr[i] || burst_len_q[i] != exp_len[i])
        $display("[TB] FAIL burst_%0d: got (%h,%0d), required (%h,%0d)",
                 i, burst_addr_q[i], burst_len_q[i], exp_addr[i], exp_len[i]);
      else passes++;
    end
  endtask

  task automatic test_fifo_stall();
    int n;
    words_acc = 0;
    words_ret = 0;
    writes    = 0;
    fifo_full = 1'b1;
    start_frame(32'h2000);
    repeat (100) tick();
    checks++;
    if (words_acc != SKID_DEPTH || m_read !== 1'b0)
      $display("[TB] FAIL stall_credit: got %0d words issued m_read %b, required %0d 0",
               words_acc, m_read, SKID_DEPTH);
    else passes++;
    checks++;
    if (overflow !== 1'b0 || f_write !== 1'b1 || writes != 0)
      $display("[TB] FAIL stall_state: got ovf %b f_write %b writes %0d, required 0 1 0",
               overflow, f_write, writes);
    else passes++;
    fifo_full = 1'b0;
    n = 0;
    while (done !== 1'b1 && n < 300) begin tick(); n++; end
    checks++;
    if (done !== 1'b1 || writes != FRAME_WORDS || exp_q.size() != 0 || overflow !== 1'b0)
      $display("[TB] FAIL stall_drain: got done %b writes %0d left %0d ovf %b, required 1 %0d 0 0",
               done, writes, exp_q.size(), overflow, FRAME_WORDS);
    else passes++;
    tick();
  endtask

  task automatic test_m_waitrequest();
    int n;
    burst_addr_q.delete();
    burst_len_q.delete();
    bursts_seen = 0;
    stall_burst = 1;
    stall_left  = 5;
    start_frame(32'h3000);
    n = 0;
    while (done !== 1'b1 && n < 300) begin tick(); n++; end
    stall_burst = -1;
    checks++;
    if (done !== 1'b1 || stall_left != 0 || burst_addr_q.size() != 3)
      $display("[TB] FAIL mwait_accepts: got done %b stall_left %0d bursts %0d, required 1 0 3",
               done, stall_left, burst_addr_q.size());
    else passes++;
    checks++;
    if (burst_addr_q.size() < 2 || burst_addr_q[1] !== 32'h3020 || burst_len_q[1] != 8)
      $display("[TB] FAIL mwait_second: got burst count %0d, required second burst (3020,8)",
               burst_addr_q.size());
    else passes++;
    tick();
  endtask

  task automatic test_start_while_busy();
    int n;
    done_cnt = 0;
    start_frame(32'h4000);
    repeat (3) tick();
    frame_base = 32'h5000;
    start      = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (done !== 1'b1 && n < 300) begin tick(); n++; end
    checks++;
    if (done !== 1'b1 || exp_q.size() != 0)
      $display("[TB] FAIL busy_start_first: got done %b left %0d, required 1 0", done, exp_q.size());
    else passes++;
    start_frame(32'h6000);
    checks++;
    if (busy !== 1'b1 || m_read !== 1'b1 || m_address !== 32'h6000)
      $display("[TB] FAIL done_cycle_start: got busy %b m_read %b addr %h, required 1 1 6000",
               busy, m_read, m_address);
    else passes++;
    n = 0;
    while (done !== 1'b1 && n < 300) begin tick(); n++; end
    tick();
    checks++;
    if (done_cnt != 2 || exp_q.size() != 0)
      $display("[TB] FAIL busy_start_second: got done_cnt %0d left %0d, required 2 0",
               done_cnt, exp_q.size());
    else passes++;
  endtask

  task automatic test_reset_mid_frame();
    int n;
    start_frame(32'h7000);
    n = 0;
    while ((words_acc - words_ret) != 6 && n < 100) begin tick(); n++; end
    checks++;
    if ((words_acc - words_ret) != 6)
      $display("[TB] FAIL reset_pending: got %0d in flight, required 6", words_acc - words_ret);
    else passes++;
    reset = 1'b1;
    exp_q.delete();
    tick();
    checks++;
    if ({busy, done, overflow, m_read, f_write} !== 5'b0 || m_address !== 32'd0 ||
        m_burstcount !== '0 || f_writedata !== 32'd0)
      $display("[TB] FAIL mid_reset_outputs: got ctrl %b addr %h bc %0d wdata %h, required all 0",
               {busy, done, overflow, m_read, f_write}, m_address, m_burstcount, f_writedata);
    else passes++;
    reset = 1'b0;
    n = 0;
    while (ret_q.size() > 0 && n < 50) begin tick(); n++; end
    repeat (3) tick();
    checks++;
    if (overflow !== 1'b0 || f_write !== 1'b0 || busy !== 1'b0 || ret_q.size() != 0)
      $display("[TB] FAIL late_returns: got ovf %b f_write %b busy %b queued %0d, required 0 0 0 0",
               overflow, f_write, busy, ret_q.size());
    else passes++;
    start_frame(32'h8000);
    n = 0;
    while (done !== 1'b1 && n < 300) begin tick(); n++; end
    checks++;
    if (done !== 1'b1 || exp_q.size() != 0 || overflow !== 1'b0)
      $display("[TB] FAIL post_reset_frame: got done %b left %0d ovf %b, required 1 0 0",
               done, exp_q.size(), overflow);
    else passes++;
    tick();
  endtask

  task automatic test_rogue_overflow();
    words_acc = 0;
    fifo_full = 1'b1;
    start_frame(32'h9000);
    repeat (40) tick();
    checks++;
    if (overflow !== 1'b0 || words_acc != SKID_DEPTH)
      $display("[TB] FAIL rogue_pre: got ovf %b issued %0d, required 0 %0d", overflow, words_acc, SKID_DEPTH);
    else passes++;
    extra_words = 1;
    repeat (3) tick();
    checks++;
    if (overflow !== 1'b1) $display("[TB] FAIL rogue_set: got ovf %b, required 1", overflow);
    else passes++;
    repeat (10) tick();
    checks++;
    if (overflow !== 1'b1) $display("[TB] FAIL rogue_sticky: got ovf %b, required 1", overflow);
    else passes++;
    reset = 1'b1;
    exp_q.delete();
    tick();
    checks++;
    if (overflow !== 1'b0) $display("[TB] FAIL rogue_clear: got ovf %b, required 0", overflow);
    else passes++;
    reset     = 1'b0;
    fifo_full = 1'b0;
    repeat (3) tick();
    checks++;
    if (f_write !== 1'b0 || busy !== 1'b0)
      $display("[TB] FAIL rogue_flushed: got f_write %b busy %b, required 0 0", f_write, busy);
    else passes++;
  endtask

  initial begin
    reset      = 1'b1;
    start      = 1'b0;
    frame_base = '0;
    test_reset();
    test_basic_frame();
    test_fifo_stall();
    test_m_waitrequest();
    test_start_while_busy();
    test_reset_mid_frame();
    test_rogue_overflow();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
